// File: rtl/spi_responder.sv
// ---------------------------------------------------------------------------
// spi_responder
//
// SPI mode-0 (CPOL=0, CPHA=0) peripheral. SCLK, CS_n and MOSI are
// oversampled on the system clock through SYNC_STAGES-deep synchronizers and
// an edge detector. Each WIDTH-bit word shifts a queued transmit word out on
// MISO, MSB first, while the MOSI word is assembled. Back-to-back words are
// supported while CS_n stays low.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   spi_sclk          SPI clock from the controller (idles low)
//   spi_cs_n          chip select, active low
//   spi_mosi          controller-to-responder data
//   spi_miso          responder-to-controller data
//   spi_miso_oe       MISO output enable, high only while selected
//   tx_data/valid     next word to transmit; accepted on tx_valid & tx_ready
//   tx_ready          one-word holding register is empty
//   rx_data           last complete received word (held until the next)
//   rx_valid          one-cycle pulse when rx_data updates
//   tx_underrun       one-cycle pulse, a word was loaded from an empty holding
//                     register (zeros are sent)
//   frame_error       one-cycle pulse, CS_n released mid-word
//   busy              high while a frame is in progress
// ---------------------------------------------------------------------------
module spi_responder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_error,
    output logic             busy
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    // Cycles after reset before every synchronizer stage and the edge
    // detector hold real pin samples rather than their reset values.
    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);

    // Synchronizer bit order: {mosi, cs_n, sclk}; idle bus is cs_n high.
    localparam logic [2:0] PINS_IDLE = 3'b010;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0]                  prev_q, prev_d;     // {cs_n, sclk} delayed
    state_t                      state_q, state_d;
    logic [SET_W-1:0]            settle_q, settle_d;
    logic                        hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]            hold_data_q, hold_data_d;
    logic [WIDTH-1:0]            tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]            rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic                        miso_q, miso_d;
    logic                        oe_q, oe_d;
    logic [WIDTH-1:0]            rx_data_q, rx_data_d;
    logic                        rx_valid_q, rx_valid_d;
    logic                        underrun_q, underrun_d;
    logic                        ferr_q, ferr_d;

    // ------------------------------------------------------------------
    // Synchronized pins and edge detection
    // ------------------------------------------------------------------
    logic [2:0] pins;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {spi_mosi, spi_cs_n, spi_sclk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign pins      = sync_q[SYNC_STAGES-1];
    assign sclk_s    = pins[0];
    assign cs_s      = pins[1];
    assign mosi_s    = pins[2];
    assign prev_d    = {cs_s, sclk_s};

    assign sclk_rise =  sclk_s & ~prev_q[0];
    assign sclk_fall = ~sclk_s &  prev_q[0];
    assign cs_rise   =  cs_s   & ~prev_q[1];
    assign cs_fall   = ~cs_s   &  prev_q[1];

    // ------------------------------------------------------------------
    // Holding register and frame control
    // ------------------------------------------------------------------
    logic accept;
    logic load;

    assign accept = tx_valid & ~hold_valid_q;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        ferr_d     = 1'b0;
        load       = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                // Only trust cs_n once the synchronizers are flushed; a reset
                // released mid-frame must not look like a fresh CS_n fall.
                if (settle_q != SET_W'(SETTLE)) begin
                    settle_d = settle_q + 1'b1;
                end else if (cs_s && prev_q[1]) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (cs_fall) begin
                    load       = 1'b1;
                    oe_d       = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    // CS_n wins over any SCLK edge seen in the same cycle.
                    if (bit_cnt_q == CNT_W'(WIDTH)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        ferr_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    oe_d      = 1'b0;
                    miso_d    = 1'b0;
                    state_d   = IDLE;
                end else if (bit_cnt_q == CNT_W'(WIDTH)) begin
                    // Word complete: publish it and wrap for a burst.
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[WIDTH-2];
                    end else begin
                        // Burst boundary: fetch the next word.
                        load = 1'b1;
                    end
                end
            end

            default: state_d = WAIT_IDLE;
        endcase

        // A load always sees the registered holding contents, so a word
        // accepted in the same cycle is kept for the following load.
        if (load) begin
            tx_shift_d = hold_valid_q ? hold_data_q : '0;
            miso_d     = hold_valid_q & hold_data_q[WIDTH-1];
            underrun_d = ~hold_valid_q;
        end

        hold_valid_d = load ? accept : (hold_valid_q | accept);
        hold_data_d  = accept ? tx_data : hold_data_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q       <= {SYNC_STAGES{PINS_IDLE}};
            prev_q       <= 2'b10;
            state_q      <= WAIT_IDLE;
            settle_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            settle_q     <= settle_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            ferr_q       <= ferr_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~hold_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_responder
//
// Acts as the SPI controller. Each frame's expected MISO words, received
// words and underrun/frame-error counts are derived from the transaction
// description and queued; a single monitor process compares whatever the
// DUT presents against those queues. The controller releases CS_n together
// with the final SCLK fall of a frame.
// ---------------------------------------------------------------------------
module tb_spi_responder;

    localparam int W    = 16;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic         spi_sclk = 1'b0;
    logic         spi_cs_n = 1'b1;
    logic         spi_mosi = 1'b0;
    logic         spi_miso, spi_miso_oe;
    logic [W-1:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, tx_underrun, frame_error, busy;

    spi_responder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Counters: written only by the monitor.
    int total = 0;
    int bad   = 0;
    int got_under = 0;
    int got_ferr  = 0;

    // Scoreboard queues and posted checks.
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] exp_miso[$];
    string        chk_name[$];
    logic [31:0]  chk_got[$];
    logic [31:0]  chk_exp[$];

    // Reference model state (main process only).
    int           exp_under = 0;
    int           exp_ferr  = 0;
    logic [W-1:0] last_rx   = '0;
    logic [W-1:0] f_mosi[4];
    logic [W-1:0] f_tx[4];
    bit           f_feed[4];
    bit           late_en   = 1'b0;
    logic [W-1:0] late_word = '0;

    task automatic cmp(input string n, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, g, e);
        end
    endtask

    task automatic post(input string n, input logic [31:0] g, input logic [31:0] e);
        chk_name.push_back(n);
        chk_got.push_back(g);
        chk_exp.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic         sclk_prev = 1'b0;
    int           nb        = 0;
    logic [W-1:0] acc       = '0;
    bit           oe_bad    = 1'b0;

    always @(negedge clock) begin
        if (rx_valid) begin
            if (exp_rx.size() == 0) cmp("rx_unexpected", 32'(rx_valid), 32'd0);
            else                    cmp("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (tx_underrun) got_under++;
        if (frame_error) got_ferr++;

        // Controller-side view of MISO, sampled at each SCLK rise.
        if (spi_cs_n) begin
            nb     = 0;
            oe_bad = 1'b0;
        end else if (spi_sclk && !sclk_prev) begin
            acc = {acc[W-2:0], spi_miso};
            if (!spi_miso_oe) oe_bad = 1'b1;
            nb++;
            if (nb == W) begin
                if (exp_miso.size() == 0) cmp("miso_unexpected", 32'(nb), 32'd0);
                else                      cmp("miso_word", 32'(acc), 32'(exp_miso.pop_front()));
                cmp("miso_oe", 32'(oe_bad), 32'd0);
                nb     = 0;
                oe_bad = 1'b0;
            end
        end
        sclk_prev = spi_sclk;

        while (chk_name.size() > 0) begin
            cmp(chk_name.pop_front(), chk_got.pop_front(), chk_exp.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic feed_word(input logic [W-1:0] d);
        int k = 0;
        while (!tx_ready && k < 50) begin
            tick(1);
            k++;
        end
        if (!tx_ready) begin
            post("tx_ready_wait", 32'(tx_ready), 32'd1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            post("tx_ready_after_accept", 32'(tx_ready), 32'd0);
        end
    endtask

    // Expected results of a complete n-word frame.
    task automatic plan(input int n);
        for (int w = 0; w < n; w++) begin
            exp_rx.push_back(f_mosi[w]);
            exp_miso.push_back(f_feed[w] ? f_tx[w] : '0);
            if (!f_feed[w]) exp_under++;
            last_rx = f_mosi[w];
        end
    endtask

    // n-word frame; abort_bits >= 0 releases CS_n after that many bits.
    task automatic run_frame(input int n, input int abort_bits);
        int nbits;
        nbits = (abort_bits >= 0) ? abort_bits : n * W;
        if (f_feed[0]) feed_word(f_tx[0]);
        spi_cs_n = 1'b0;
        if (late_en) begin
            // tx_valid lands in exactly the cycle the CS_n-fall load happens.
            tick(SS);
            tx_data  = late_word;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            post("late_hold_full", 32'(tx_ready), 32'd0);
            tick(HALF - SS - 1);
        end else begin
            tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            int w;
            int b;
            w = i / W;
            b = i % W;
            spi_mosi = f_mosi[w][W-1-b];
            tick(HALF);
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
            if (abort_bits < 0 && i == nbits - 1) spi_cs_n = 1'b1;
            if (b == 3 && w + 1 < n && f_feed[w+1]) feed_word(f_tx[w+1]);
        end
        if (abort_bits >= 0) begin
            tick(HALF);
            spi_cs_n = 1'b1;
        end
        spi_mosi = 1'b0;
        tick(10);
    endtask

    task automatic check_reset(input string t);
        post({t, "_miso"},     32'(spi_miso),    32'd0);
        post({t, "_oe"},       32'(spi_miso_oe), 32'd0);
        post({t, "_tx_ready"}, 32'(tx_ready),    32'd1);
        post({t, "_rx_data"},  32'(rx_data),     32'd0);
        post({t, "_rx_valid"}, 32'(rx_valid),    32'd0);
        post({t, "_underrun"}, 32'(tx_underrun), 32'd0);
        post({t, "_ferr"},     32'(frame_error), 32'd0);
        post({t, "_busy"},     32'(busy),        32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        tick(3);
        check_reset("rst");
        reset = 1'b0;
        tick(SS + 6);

        // Single word.
        f_tx[0] = 16'hA5C3; f_mosi[0] = 16'h1234; f_feed[0] = 1'b1;
        plan(1);
        run_frame(1, -1);
        post("t1_rx_data", 32'(rx_data), 32'h1234);

        // Two-word burst, second word fed mid-frame.
        f_tx[0] = 16'h0F0F; f_mosi[0] = 16'hBEEF; f_feed[0] = 1'b1;
        f_tx[1] = 16'hF0F0; f_mosi[1] = 16'h5A5A; f_feed[1] = 1'b1;
        plan(2);
        run_frame(2, -1);
        post("burst_underrun", 32'(got_under), 32'(exp_under));

        // Empty holding register at CS_n fall.
        f_mosi[0] = 16'hC001; f_feed[0] = 1'b0;
        plan(1);
        run_frame(1, -1);
        post("empty_underrun", 32'(got_under), 32'(exp_under));

        // CS_n released after 7 bits.
        f_tx[0] = 16'h7777; f_mosi[0] = 16'hDEAD; f_feed[0] = 1'b1;
        exp_ferr++;
        run_frame(1, 7);
        post("abort_ferr", 32'(got_ferr), 32'(exp_ferr));
        post("abort_rx_kept", 32'(rx_data), 32'(last_rx));
        post("abort_tx_ready", 32'(tx_ready), 32'd1);
        f_tx[0] = 16'h1357; f_mosi[0] = 16'h2468; f_feed[0] = 1'b1;
        plan(1);
        run_frame(1, -1);

        // Reset at bit 9 with CS_n held low.
        feed_word(16'h9999);
        spi_cs_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < 9; i++) begin
            spi_mosi = i[0];
            tick(HALF);
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
        reset = 1'b1;
        tick(2);
        check_reset("rst_mid");
        reset = 1'b0;
        tick(20);
        post("post_rst_busy", 32'(busy), 32'd0);
        post("post_rst_oe", 32'(spi_miso_oe), 32'd0);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(10);
        f_tx[0] = 16'h8421; f_mosi[0] = 16'h0FF0; f_feed[0] = 1'b1;
        plan(1);
        run_frame(1, -1);
        post("post_rst_rx", 32'(rx_data), 32'h0FF0);

        // tx_valid in the CS_n-fall load cycle with holding empty.
        late_word = 16'h6C6C;
        f_feed[0] = 1'b0; f_feed[1] = 1'b0;
        f_mosi[0] = 16'hAAAA; f_mosi[1] = 16'h5555;
        exp_rx.push_back(f_mosi[0]);
        exp_rx.push_back(f_mosi[1]);
        exp_miso.push_back('0);
        exp_miso.push_back(late_word);
        exp_under++;
        last_rx = f_mosi[1];
        late_en = 1'b1;
        run_frame(2, -1);
        late_en = 1'b0;
        post("late_underrun", 32'(got_under), 32'(exp_under));
        post("late_tx_ready", 32'(tx_ready), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int w = 0; w < n; w++) begin
                f_mosi[w] = W'($urandom);
                f_tx[w]   = W'($urandom);
                f_feed[w] = ($urandom_range(0, 3) != 0);
            end
            plan(n);
            run_frame(n, -1);
        end

        post("final_underrun", 32'(got_under), 32'(exp_under));
        post("final_ferr", 32'(got_ferr), 32'(exp_ferr));
        post("final_rx_data", 32'(rx_data), 32'(last_rx));
        post("rx_left", 32'(exp_rx.size()), 32'd0);
        post("miso_left", 32'(exp_miso.size()), 32'd0);
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
